// File: rtl/leg_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | leg_pc_unit : LEG program counter, branch resolution and return-address stack
// | Revision 1.0
// +----------------------------------------------------------------------------
module leg_pc_unit #(
  parameter int STEP        = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           advance,
  input  logic                           is_branch,
  input  logic                           cond_taken,
  input  logic                           call,
  input  logic                           ret,
  input  logic [7:0]                     jump_target,
  output logic [7:0]                     pc,
  output logic                           redirect,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           stack_empty,
  output logic                           stack_full,
  output logic                           fault
);

  localparam int              AW      = $clog2(STACK_DEPTH);
  localparam int              DW      = AW + 1;
  localparam logic [7:0]      STEP_W  = 8'(STEP);
  localparam logic [DW-1:0]   FULL_W  = DW'(STACK_DEPTH);
  localparam logic [DW-1:0]   ONE_W   = DW'(1);

  logic [7:0]    pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          redirect_q, redirect_d;
  logic          fault_q, fault_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic [7:0]    stack_q [STACK_DEPTH];
  logic [7:0]    stack_d [STACK_DEPTH];

  logic [7:0]    pc_seq;
  logic [DW-1:0] depth_m1;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;

  always_comb begin
    pc_seq     = pc_q + STEP_W;
    depth_m1   = depth_q - ONE_W;
    push_idx   = depth_q[AW-1:0];
    pop_idx    = depth_m1[AW-1:0];
    pc_d       = pc_q;
    depth_d    = depth_q;
    redirect_d = 1'b0;
    fault_d    = fault_q;
    stack_d    = stack_q;

    // One action per retired instruction, priority ret > call > branch > sequential.
    if (advance && !fault_q) begin
      if (ret) begin
        if (empty_q) begin
          fault_d = 1'b1;
        end else begin
          pc_d       = stack_q[pop_idx];
          depth_d    = depth_m1;
          redirect_d = 1'b1;
        end
      end else if (call) begin
        if (full_q) begin
          fault_d = 1'b1;
        end else begin
          stack_d[push_idx] = pc_seq;
          pc_d              = jump_target;
          depth_d           = depth_q + ONE_W;
          redirect_d        = 1'b1;
        end
      end else if (is_branch && cond_taken) begin
        pc_d       = jump_target;
        redirect_d = 1'b1;
      end else begin
        pc_d = pc_seq;
      end
    end

    empty_d = (depth_d == '0);
    full_d  = (depth_d == FULL_W);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= '0;
      depth_q    <= '0;
      redirect_q <= 1'b0;
      fault_q    <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      depth_q    <= depth_d;
      redirect_q <= redirect_d;
      fault_q    <= fault_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
    end
  end

  // Entries above depth are never read, so the array needs no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign pc          = pc_q;
  assign redirect    = redirect_q;
  assign depth       = depth_q;
  assign stack_empty = empty_q;
  assign stack_full  = full_q;
  assign fault       = fault_q;

endmodule
`default_nettype wire

// File: doc/leg_pc_unit.md
# leg_pc_unit

Program-counter and branch-resolution stage for the LEG core, directly downstream of the signed condition comparator. It consumes the comparator's 1-bit condition result together with the decoded branch, call and return strobes. It holds the 8-bit program counter, redirects it on taken branches, calls and returns, and keeps a bounded return-address stack. Its `pc` output addresses program memory for the next fetch.

## Interface
Parameters:
- `STEP`, 4: byte increment per sequential instruction (LEG instructions are 4 bytes).
- `STACK_DEPTH`, 8: return-address stack entries; must be a power of two, 2..16.

Ports:
- `clk`  in  1: the single clock, rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `advance`  in  1: instruction-retire strobe. The PC and stack change only on edges where this is 1; when 0 the unit stalls.
- `is_branch`  in  1: the current instruction is a conditional jump (opcode condition 8..11).
- `cond_taken`  in  1: comparator output; meaningful only while `is_branch`=1.
- `call`  in  1: the current instruction is CALL.
- `ret`  in  1: the current instruction is RET.
- `jump_target`  in  8: target address for a branch or call.
- `pc`  out  8: current program counter.
- `redirect`  out  1: registered; 1 for the cycle after any non-sequential PC update. Fetch uses it to flush.
- `depth`  out  $clog2(STACK_DEPTH)+1: number of occupied stack entries.
- `stack_empty`  out  1: `depth`==0.
- `stack_full`  out  1: `depth`==STACK_DEPTH.
- `fault`  out  1: sticky error flag, cleared only by reset.

## Operation
- Reset values: `pc`=0, `depth`=0, `stack_empty`=1, `stack_full`=0, `redirect`=0, `fault`=0. Stack contents are don't-care.
- When `advance`=1 and `fault`=0, exactly one action is taken, chosen by priority **ret > call > branch > sequential**:
  - **RET**:
    - Stack non-empty: pop; `pc` takes the popped address; `redirect` next cycle is 1.
    - Stack empty (underflow): `fault` is set, `pc` holds, no pop.
  - **CALL**:
    - Stack not full: push (`pc`+STEP) mod 256; `pc` takes `jump_target`; `redirect` is 1.
    - Stack full (overflow): `fault` is set, `pc` holds, no push, the oldest entry is never overwritten.
  - **BRANCH** (`is_branch`=1):
    - `cond_taken`=1: `pc` takes `jump_target`; `redirect` is 1.
    - `cond_taken`=0: same as sequential.
  - **SEQUENTIAL**: `pc` takes (`pc`+STEP) mod 256. An 8-bit wrap is legal, e.g. 252 goes to 0. `redirect` is 0.
- `advance`=0: all state holds and `redirect` goes to 0 on that edge.
- Lower-priority strobes asserted together with a higher one are ignored; they do not set `fault`.
- Once `fault`=1:
  - `pc`, the stack and `depth` freeze regardless of `advance`, and `redirect` stays 0.
  - Only reset recovers.
- The stack is LIFO, implemented as a register array indexed by `depth`:
  - Push writes entry[`depth`].
  - Pop reads entry[`depth`-1].
  - Simultaneous push and pop cannot occur because of the priority rule.
- The `jump_target` value is used as given. There is no alignment check; odd targets are legal.

## Timing
- All state is updated on the `clk` rising edge. `rst` low clears state immediately, independent of `clk`.
- When `rst` is released, the first update happens on the first rising edge on which `advance`=1.
- `pc` latency: an action sampled at edge N is visible on `pc` immediately after edge N.
- `redirect`, `depth`, `stack_empty`, `stack_full` and `fault` are registered. They change on the same edge as `pc`.
- Inputs are sampled only at the rising edge. Combinational glitches on `cond_taken` between edges have no effect.
- Reset asserted mid-stall or mid-call discards any pending action. The stack is empty afterwards.

## Test plan
- **Reset and sequential run:**
  - Hold `rst` low, then release it and apply 3 edges with `advance`=1 and no strobes.
  - Required: `pc` reads 0→4→8→12, `redirect`=0 throughout, `stack_empty`=1.
- **Taken vs not-taken branch:**
  - At `pc`=12, apply `is_branch`=1, `cond_taken`=1, `jump_target`=40.
  - Required: `pc`=40 and `redirect`=1 for one cycle.
  - Then at 40, apply `is_branch`=1, `cond_taken`=0.
  - Required: `pc`=44, `redirect`=0.
- **Call/return and priority:**
  - At `pc`=20, apply `call` with `jump_target`=100.
  - Required: `pc`=100, `depth`=1.
  - Next, apply `ret`=1 together with `call`=1 and `is_branch`=1.
  - Required: RET wins, `pc`=24, `depth`=0, `fault`=0.
- **Overflow:**
  - Apply 8 calls, which sets `stack_full`=1, then a 9th call.
  - Required: `fault`=1, `pc` holds at its pre-9th-call value, `depth`=8.
  - Required: further `advance` pulses leave everything frozen.
- **Underflow and recovery:**
  - After reset, apply `ret` at `pc`=4.
  - Required: `fault`=1, `pc`=4.
  - Pulse `rst` low asynchronously, mid-cycle.
  - Required: `pc`=0 and `fault`=0 immediately, before the next edge.
- **Wrap and stall:**
  - At `pc`=252 with `advance`=1, apply an edge.
  - Required: `pc`=0.
  - Then hold `advance`=0 with `is_branch`=1, `cond_taken`=1, `jump_target`=80 for 3 edges.
  - Required: `pc` stays 0 and `redirect`=0.
